// File: rtl/tdc_pkg.sv
// ============================================================================
// Module  : tdc_pkg
// Brief   : Shared types, default parameters and command ROM contents for
//           the TDC command sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package tdc_pkg;

    localparam int c_num_cfg  = 9;
    localparam int c_num_rd   = 3;
    localparam int c_rd_bytes = 3;
    localparam int c_w        = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_SEND    = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SEQ_INIT = 2'd0,
        SEQ_MEAS = 2'd1,
        SEQ_READ = 2'd2
    } seq_e;

    // Layout: config write pairs, measurement start pair, readout addresses.
    localparam int c_rom_depth = 2 * c_num_cfg + 2 + 4;
    localparam logic [7:0] c_rom [c_rom_depth] = '{
        8'h41, 8'h40, 8'h42, 8'h1F, 8'h43, 8'h07, 8'h44, 8'hFF,
        8'h45, 8'hFF, 8'h46, 8'hFF, 8'h47, 8'hFF, 8'h48, 8'h00,
        8'h49, 8'h00,
        8'h40, 8'h81,
        8'h10, 8'h1B, 8'h1C, 8'h11
    };

    function automatic logic [7:0] rom_entry(input int idx);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < c_rom_depth; i++) begin
            if (idx == i) v = c_rom[i];
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_cmd_rom.sv
// ============================================================================
// Module  : tdc_cmd_rom
// Brief   : Registered command ROM lookup, one cycle of read latency.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdc_cmd_rom #(
    parameter int W  = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  data
);
    import tdc_pkg::*;

    logic [W-1:0] data_d;
    logic [W-1:0] data_q;

    always_comb begin
        data_d = W'(rom_entry(int'(addr)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/tdc_cmd_seq.sv
// ============================================================================
// Module  : tdc_cmd_seq
// Brief   : Command sequencer driving init/measure/readout byte streams to an
//           SPI master and collecting readout results.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdc_cmd_seq #(
    parameter int NUM_CFG  = tdc_pkg::c_num_cfg,
    parameter int NUM_RD   = tdc_pkg::c_num_rd,
    parameter int RD_BYTES = tdc_pkg::c_rd_bytes,
    parameter int W        = tdc_pkg::c_w
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_init,
    input  logic                         cmd_meas,
    input  logic                         cmd_read,
    output logic                         busy,
    output logic [W-1:0]                 tx_data,
    output logic                         tx_valid,
    output logic                         tx_last,
    input  logic                         tx_ready,
    input  logic [W-1:0]                 rx_data,
    input  logic                         rx_valid,
    output logic [NUM_RD*RD_BYTES*W-1:0] res,
    output logic                         res_valid,
    output logic                         err
);
    import tdc_pkg::*;

    localparam int c_fw    = RD_BYTES * W;
    localparam int c_res_w = NUM_RD * c_fw;
    localparam int c_total = 2 * NUM_CFG + 2 + NUM_RD * (1 + RD_BYTES);
    localparam int c_cnt_w = $clog2(c_total + 1);

    state_e               state_q, state_d;
    seq_e                 seq_q, seq_d;
    logic [c_cnt_w-1:0]   frame_q, frame_d;
    logic [c_cnt_w-1:0]   pos_q, pos_d;
    logic [c_cnt_w-1:0]   rx_cnt_q, rx_cnt_d;
    logic [c_res_w-1:0]   shadow_q, shadow_d;
    logic [c_res_w-1:0]   res_q, res_d;
    logic                 res_valid_q, res_valid_d;
    logic                 err_q, err_d;

    logic [c_cnt_w-1:0]   frame_len;
    logic [c_cnt_w-1:0]   seq_len;
    logic [c_cnt_w-1:0]   rom_addr;
    logic [W-1:0]         rom_data;
    logic                 any_cmd;
    logic                 rx_take;
    logic                 rx_done;
    logic                 is_data_byte;

    tdc_cmd_rom #(
        .W  (W),
        .AW (c_cnt_w)
    ) u_rom (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (rom_addr),
        .data  (rom_data)
    );

    // frame_q/pos_q always point at the byte being fetched, sent or answered
    always_comb begin
        frame_len = c_cnt_w'(2);
        seq_len   = c_cnt_w'(2 * NUM_CFG);
        rom_addr  = (frame_q << 1) + pos_q;
        case (seq_q)
            SEQ_MEAS: begin
                seq_len  = c_cnt_w'(2);
                rom_addr = c_cnt_w'(2 * NUM_CFG) + pos_q;
            end
            SEQ_READ: begin
                frame_len = c_cnt_w'(1 + RD_BYTES);
                seq_len   = c_cnt_w'(NUM_RD * (1 + RD_BYTES));
                rom_addr  = c_cnt_w'(2 * NUM_CFG + 2) + frame_q;
            end
            default: ;
        endcase
    end

    assign any_cmd      = cmd_init | cmd_meas | cmd_read;
    assign rx_take      = (state_q == ST_WAIT_RX) && rx_valid;
    assign rx_done      = rx_take && (rx_cnt_q == seq_len - c_cnt_w'(1));
    assign is_data_byte = (seq_q == SEQ_READ) && (pos_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_cmd) state_d = ST_FETCH;
            ST_FETCH:   state_d = ST_SEND;
            ST_SEND:    if (tx_ready) state_d = ST_WAIT_RX;
            ST_WAIT_RX: if (rx_valid) state_d = rx_done ? ST_DONE : ST_FETCH;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        tx_data  = '0;
        case (state_q)
            ST_FETCH, ST_WAIT_RX: busy = 1'b1;
            ST_SEND: begin
                busy     = 1'b1;
                tx_valid = 1'b1;
                tx_last  = (pos_q == frame_len - c_cnt_w'(1));
                tx_data  = is_data_byte ? '0 : rom_data;
            end
            default: ;
        endcase
    end

    always_comb begin
        seq_d       = seq_q;
        frame_d     = frame_q;
        pos_d       = pos_q;
        rx_cnt_d    = rx_cnt_q;
        shadow_d    = shadow_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        err_d       = 1'b0;

        // Commands are only accepted from IDLE; everything else is flagged.
        if (state_q == ST_IDLE) begin
            err_d = (cmd_init & (cmd_meas | cmd_read)) | (cmd_meas & cmd_read);
            if (any_cmd) begin
                seq_d    = cmd_init ? SEQ_INIT : (cmd_meas ? SEQ_MEAS : SEQ_READ);
                frame_d  = '0;
                pos_d    = '0;
                rx_cnt_d = '0;
            end
        end else begin
            err_d = any_cmd;
        end

        if (rx_take) begin
            rx_cnt_d = rx_cnt_q + c_cnt_w'(1);
            if (pos_q == frame_len - c_cnt_w'(1)) begin
                pos_d   = '0;
                frame_d = frame_q + c_cnt_w'(1);
            end else begin
                pos_d = pos_q + c_cnt_w'(1);
            end
            if (is_data_byte) begin
                for (int f = 0; f < NUM_RD; f++) begin
                    if (frame_q == c_cnt_w'(f)) begin
                        shadow_d[f*c_fw +: c_fw] = c_fw'({shadow_q[f*c_fw +: c_fw], rx_data});
                    end
                end
            end
            if (rx_done && (seq_q == SEQ_READ)) begin
                res_d       = shadow_d;
                res_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_q       <= SEQ_INIT;
            frame_q     <= '0;
            pos_q       <= '0;
            rx_cnt_q    <= '0;
            shadow_q    <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            seq_q       <= seq_d;
            frame_q     <= frame_d;
            pos_q       <= pos_d;
            rx_cnt_q    <= rx_cnt_d;
            shadow_q    <= shadow_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_q       <= err_d;
        end
    end

    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: doc/tdc_cmd_seq.md
TDC_CMD_SEQ -- requirements
Module: tdc_cmd_seq

Interface
REQ-001 SHALL have parameter NUM_CFG, default 9, meaning the number of 2-byte config frames in the init sequence.
REQ-002 SHALL have parameter NUM_RD, default 3, range 1..4, meaning the number of readout frames (TIME1, CALIB1, CALIB2, spare).
REQ-003 SHALL have parameter RD_BYTES, default 3, range 1..4, meaning the number of data bytes per readout frame.
REQ-004 SHALL have parameter W, default 8, meaning the SPI byte width.
REQ-005 SHALL have port clk  in  1  the single clock.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports cmd_init, cmd_meas, cmd_read  in  1 each  single-cycle command requests.
REQ-008 SHALL have port busy  out  1  high while any sequence is in progress.
REQ-009 SHALL have ports tx_data  out  W, tx_valid  out  1, tx_last  out  1 (CS deasserts after this byte), and tx_ready  in  1, forming the byte stream to the SPI master.
REQ-010 SHALL have ports rx_data  in  W and rx_valid  in  1, carrying one received byte per transmitted byte, in order.
REQ-011 SHALL have port res  out  NUM_RD*RD_BYTES*W  packed readout results, frame 0 in the LSBs.
REQ-012 SHALL have ports res_valid  out  1 (one-cycle pulse) and err  out  1 (one-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, FETCH, SEND, WAIT_RX and DONE.
REQ-014 SHALL, in IDLE, accept one command per cycle with priority init > meas > read; lower-priority simultaneous commands are dropped and err pulses.
REQ-015 SHALL pulse err and ignore any command that arrives while busy, without disturbing the running sequence.
REQ-016 SHALL use an init sequence of ROM entries 0..2*NUM_CFG-1 sent as NUM_CFG frames of 2 bytes each, with tx_last on every second byte.
REQ-017 SHALL use a meas sequence of one 2-byte frame taken from the two ROM entries after the config block (defaults 0x40, 0x81).
REQ-018 SHALL use a read sequence of NUM_RD frames, each consisting of an address byte from the ROM followed by RD_BYTES bytes of 0x00, with tx_last on the final byte of each frame.
REQ-019 SHALL read the ROM with registered data (1-cycle latency); tx_valid rises exactly 2 cycles after the command cycle.
REQ-020 SHALL hold tx_data, tx_valid and tx_last stable until tx_ready is high; a byte transfers when tx_valid and tx_ready are both high.
REQ-021 SHALL present the next byte no earlier than 2 cycles after the previous transfer (FETCH cycle between bytes).
REQ-022 SHALL, for read frames, discard the rx byte paired with the address byte and shift data bytes MSB-first into the frame's RD_BYTES*W slot of res.
REQ-023 SHALL keep res unchanged until the final rx byte of a read sequence, then update it, and pulse res_valid in the following cycle.
REQ-024 SHALL, for init and meas sequences, count but ignore rx bytes; busy falls after the last byte's rx_valid.
REQ-025 SHALL raise busy in the command cycle plus one and drop it in the DONE cycle; DONE returns to IDLE after 1 cycle.
REQ-026 SHALL treat an rx_valid with no outstanding transmitted byte as ignored, setting no state.
REQ-027 SHALL size the byte counters to cover 2*NUM_CFG+2+NUM_RD*(1+RD_BYTES) entries without wrap-around.

Reset
REQ-028 SHALL, while rst_n is low, force state to IDLE, clear all counters, and drive busy, tx_valid, tx_last, tx_data, res, res_valid and err to 0.
REQ-029 SHALL, when reset asserts mid-sequence, abandon the sequence without emitting further bytes, and leave res cleared.

Structure
REQ-030 SHALL place the ROM contents constant, the state enum and the default parameter values in a shared package tdc_pkg.
REQ-031 SHALL use one sub-module, tdc_cmd_rom: a parametrised registered lookup (address in, W-bit data out) whose contents come from tdc_pkg.

Verification
REQ-032 SHALL verify that cmd_init with tx_ready held high produces 18 bytes (first pair 0x41,0x40; 9 tx_last pulses), then busy falls, err=0.
REQ-033 SHALL verify that cmd_meas produces bytes 0x40,0x81 with tx_last on 0x81, and tx_valid first rises 2 cycles after cmd_meas.
REQ-034 SHALL verify that cmd_read with rx bytes for TIME1 = 0x01,0x23,0x45, CALIB1 = 0x00,0x0F,0xA0 and CALIB2 = 0x00,0x9C,0x40 gives res = {0x009C40,0x000FA0,0x012345} and one res_valid pulse.
REQ-035 SHALL verify that tx_ready held low for 5 cycles mid-frame keeps tx_data stable and causes no byte loss or duplication.
REQ-036 SHALL verify that cmd_meas issued during an init sequence pulses err once and leaves the init byte stream unchanged; cmd_init and cmd_read in the same cycle start init only and pulse err.
REQ-037 SHALL verify that rst_n pulsed low during byte 7 of init drops tx_valid and busy immediately, and that a following cmd_meas runs normally.
